// File: rtl/packet_ram_pkg.sv
// Shared types and helpers for the packet RAM.
//   rd_size_e : load size encodings (11 behaves as a word load)
//   nbytes    : number of bytes touched by a load of a given size
//   strb_hi   : highest byte offset covered by a write strobe vector
package packet_ram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } rd_size_e;

    function automatic logic [2:0] nbytes(input rd_size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Strobe bit i covers byte offset nb-1-i. Scanning from the MSB (offset 0)
    // downwards, the last set bit seen gives the highest offset.
    function automatic logic [2:0] strb_hi(input logic [7:0] strb, input int nb);
        logic [2:0] hi;
        hi = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i < nb && strb[i]) begin
                hi = 3'(nb - 1 - i);
            end
        end
        return hi;
    endfunction

endpackage

// File: rtl/packet_ram_2r1w.sv
// Byte-strobed write port with two synchronous read ports, built as two
// identical simple-dual-port RAM copies that share the write port.
// Reads are read-first: a same-cycle write to the read word returns old data.
// Ports:
//   clk                        clock
//   wr_en/wr_addr/wr_data/wr_strb  write port, wr_strb[i] enables wr_data[8i+7:8i]
//   rd_en                      read enable for both ports
//   rd0_addr/rd0_data          read port 0, data one cycle after the address
//   rd1_addr/rd1_data          read port 1, data one cycle after the address
module packet_ram_2r1w #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd0_addr,
    output logic [DATA_WIDTH-1:0]   rd0_data,
    input  logic [ADDR_WIDTH-1:0]   rd1_addr,
    output logic [DATA_WIDTH-1:0]   rd1_data
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] mem1 [DEPTH];
    logic [DATA_WIDTH-1:0] rd0_q;
    logic [DATA_WIDTH-1:0] rd1_q;

    // RAM arrays and their output registers carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wr_strb[i]) begin
                    mem0[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    mem1[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd0_q <= mem0[rd0_addr];
            rd1_q <= mem1[rd1_addr];
        end
    end

    assign rd0_data = rd0_q;
    assign rd1_data = rd1_q;

endmodule

// File: rtl/packet_ram_unaligned.sv
// Packet buffer with byte-strobed word writes and unaligned big-endian
// 1/2/4-byte loads (fixed latency 2, one load per cycle), plus packet
// length tracking. Optional out-of-bounds checking is enabled by defining
// PACKET_RAM_OOB_CHECK_EN; otherwise rd_oob is tied low and no comparator exists.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_en/wr_addr/wr_data/wr_strb  word write, MSB byte/strobe = lowest address
//   rd_en/rd_addr/rd_size      byte-addressed load request
//   rd_data/rd_valid/rd_oob    load result, right-justified and zero-extended
//   len_rst                    synchronous clear of len (wins over a write update)
//   len                        packet length in bytes
module packet_ram_unaligned
    import packet_ram_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 10,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned BYTES      = DATA_WIDTH / 8,
    localparam int unsigned OFF_W      = $clog2(BYTES),
    localparam int unsigned BA_WIDTH   = ADDR_WIDTH + OFF_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BYTES-1:0]      wr_strb,
    input  logic                  rd_en,
    input  logic [BA_WIDTH-1:0]   rd_addr,
    input  logic [1:0]            rd_size,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob,
    input  logic                  len_rst,
    output logic [31:0]           len
);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("packet_ram_unaligned: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] word0_c, word1_c;
    logic [DATA_WIDTH-1:0] ram0_data, ram1_data;

    logic                  s1_valid_d, s1_valid_q;
    logic [OFF_W-1:0]      s1_off_d, s1_off_q;
    rd_size_e              s1_size_d, s1_size_q;
    logic                  rd_valid_d, rd_valid_q;
    logic [31:0]           rd_data_d, rd_data_q;
    logic [31:0]           len_d, len_q;

    logic [2*DATA_WIDTH-1:0] cat_c;
    logic [31:0]             win_c;
    logic [31:0]             ext_c;
    logic [2:0]              wr_hi_c;
    logic [31:0]             wr_end_c;

    // The second word wraps to 0 at the top of the RAM.
    assign word0_c = rd_addr[BA_WIDTH-1:OFF_W];
    assign word1_c = ADDR_WIDTH'(word0_c + 1'b1);

    packet_ram_2r1w #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .rd_en    (rd_en),
        .rd0_addr (word0_c),
        .rd0_data (ram0_data),
        .rd1_addr (word1_c),
        .rd1_data (ram1_data)
    );

`ifdef PACKET_RAM_OOB_CHECK_EN
    logic s1_oob_d, s1_oob_q;
    logic rd_oob_d, rd_oob_q;

    // Uses len before any same-cycle update; 33 bits so the sum cannot wrap.
    always_comb begin
        s1_oob_d = (33'(rd_addr) + 33'(nbytes(rd_size_e'(rd_size)))) > 33'(len_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_oob_q <= 1'b0;
            rd_oob_q <= 1'b0;
        end else begin
            s1_oob_q <= s1_oob_d;
            rd_oob_q <= rd_oob_d;
        end
    end

    assign rd_oob_d = s1_valid_q ? s1_oob_q : rd_oob_q;
    assign rd_oob   = rd_oob_q;
`else
    assign rd_oob = 1'b0;
`endif

    // Stage 0 capture, alignment/extraction, and len update.
    always_comb begin
        s1_valid_d = rd_en;
        s1_off_d   = rd_en ? rd_addr[OFF_W-1:0] : s1_off_q;
        s1_size_d  = rd_en ? rd_size_e'(rd_size) : s1_size_q;

        // Big-endian: shifting the pair left by the offset puts the first
        // addressed byte at the top of the window.
        cat_c = {ram0_data, ram1_data};
        win_c = 32'((cat_c << {s1_off_q, 3'b000}) >> (2*DATA_WIDTH - 32));
        case (s1_size_q)
            SZ_BYTE: ext_c = 32'(win_c[31:24]);
            SZ_HALF: ext_c = 32'(win_c[31:16]);
            default: ext_c = win_c;
        endcase
`ifdef PACKET_RAM_OOB_CHECK_EN
        if (s1_oob_q) begin
            ext_c = 32'd0;
        end
`endif
        rd_valid_d = s1_valid_q;
        rd_data_d  = s1_valid_q ? ext_c : rd_data_q;

        wr_hi_c  = strb_hi(8'(wr_strb), int'(BYTES));
        wr_end_c = (32'(wr_addr) << OFF_W) + 32'(wr_hi_c) + 32'd1;
        len_d    = len_q;
        if (len_rst) begin
            len_d = 32'd0;
        end else if (wr_en && (|wr_strb) && (wr_end_c > len_q)) begin
            len_d = wr_end_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_off_q   <= '0;
            s1_size_q  <= SZ_BYTE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            len_q      <= 32'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_off_q   <= s1_off_d;
            s1_size_q  <= s1_size_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            len_q      <= len_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign len      = len_q;

endmodule

// File: tb/tb_packet_ram_unaligned.sv
// Directed, table-driven bench for packet_ram_unaligned (DATA_WIDTH=32).
// Expected values follow PACKET_RAM_OOB_CHECK_EN if it is defined for the build.
module tb_packet_ram_unaligned;

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned BAW = 12;

`ifdef PACKET_RAM_OOB_CHECK_EN
    localparam bit OOB_EN = 1'b1;
`else
    localparam bit OOB_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;
    logic          rd_en;
    logic [BAW-1:0] rd_addr;
    logic [1:0]    rd_size;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          rd_oob;
    logic          len_rst;
    logic [31:0]   len;

    packet_ram_unaligned #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_size  (rd_size),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_oob   (rd_oob),
        .len_rst  (len_rst),
        .len      (len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [BAW-1:0] addr;
        logic [1:0]     size;
        logic [31:0]    exp_data;
        logic           exp_oob;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input logic lrst);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
        len_rst = lrst;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        wr_strb = 4'h0;
        len_rst = 1'b0;
    endtask

    // Issue one load, check latency, result, and hold after rd_valid drops.
    task automatic do_load(input string name, input logic [BAW-1:0] a, input logic [1:0] s,
                           input logic [31:0] exp_d, input logic exp_o);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_size = s;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk({name, " early_valid"}, 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, " valid"}, 32'(rd_valid), 32'd1);
        chk({name, " data"}, rd_data, exp_d);
        chk({name, " oob"}, 32'(rd_oob), 32'(exp_o));
        @(posedge clk); #1;
        chk({name, " valid_drop"}, 32'(rd_valid), 32'd0);
        chk({name, " data_hold"}, rd_data, exp_d);
    endtask

    initial begin
        logic [31:0] b2b_exp [4];

        // Memory image: w0=11223344 w1=55667788 w2=99EEFF00, len=8
        tbl[0]  = '{12'd3, 2'b10, 32'h44556677, 1'b0};
        tbl[1]  = '{12'd5, 2'b00, 32'h00000066, 1'b0};
        tbl[2]  = '{12'd0, 2'b10, 32'h11223344, 1'b0};
        tbl[3]  = '{12'd1, 2'b01, 32'h00002233, 1'b0};
        tbl[4]  = '{12'd6, 2'b00, 32'h00000077, 1'b0};
        tbl[5]  = '{12'd4, 2'b10, 32'h55667788, 1'b0};
        tbl[6]  = '{12'd0, 2'b11, 32'h11223344, 1'b0};
        tbl[7]  = '{12'd7, 2'b01, OOB_EN ? 32'h0 : 32'h00008899, OOB_EN};
        tbl[8]  = '{12'd5, 2'b10, OOB_EN ? 32'h0 : 32'h66778899, OOB_EN};
        // After byte 9 written with BB: w2=99BBFF00, len=10
        tbl[9]  = '{12'd9, 2'b00, 32'h000000BB, 1'b0};
        tbl[10] = '{12'd8, 2'b00, 32'h00000099, 1'b0};
        tbl[11] = '{12'd9, 2'b01, OOB_EN ? 32'h0 : 32'h0000BBFF, OOB_EN};
        tbl[12] = '{12'd8, 2'b01, 32'h000099BB, 1'b0};

        b2b_exp[0] = 32'h11223344;
        b2b_exp[1] = 32'h22334455;
        b2b_exp[2] = 32'h33445566;
        b2b_exp[3] = 32'h44556677;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_strb = 4'h0;
        rd_en   = 1'b0;
        rd_addr = '0;
        rd_size = 2'b00;
        len_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset rd_oob", 32'(rd_oob), 32'd0);
        chk("reset rd_data", rd_data, 32'd0);
        chk("reset len", len, 32'd0);

        // Seed word2 so its byte0 is known, then clear len.
        do_write(1'b1, 10'd2, 32'h99EEFF00, 4'hF, 1'b0);
        chk("len seed", len, 32'd12);
        do_write(1'b0, 10'd0, 32'h0, 4'h0, 1'b1);
        chk("len clear", len, 32'd0);

        do_write(1'b1, 10'd0, 32'h11223344, 4'hF, 1'b0);
        do_write(1'b1, 10'd1, 32'h55667788, 4'hF, 1'b0);
        chk("len after w0 w1", len, 32'd8);

        for (int i = 0; i < 9; i++) begin
            do_load($sformatf("vec%0d", i), tbl[i].addr, tbl[i].size, tbl[i].exp_data, tbl[i].exp_oob);
        end

        do_write(1'b1, 10'd2, 32'hAABBCCDD, 4'b0100, 1'b0);
        chk("len partial strb", len, 32'd10);

        for (int i = 9; i < 13; i++) begin
            do_load($sformatf("vec%0d", i), tbl[i].addr, tbl[i].size, tbl[i].exp_data, tbl[i].exp_oob);
        end

        // Back-to-back word loads at byte addresses 0..3.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                rd_en   = 1'b1;
                rd_addr = BAW'(i);
                rd_size = 2'b10;
            end else begin
                rd_en = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 1 && i <= 4) begin
                chk($sformatf("b2b%0d valid", i - 1), 32'(rd_valid), 32'd1);
                chk($sformatf("b2b%0d data", i - 1), rd_data, b2b_exp[i-1]);
            end else if (i == 5) begin
                chk("b2b end valid", 32'(rd_valid), 32'd0);
            end
        end

        // len_rst wins over the len update, but the RAM write still lands.
        do_write(1'b1, 10'd3, 32'h01020304, 4'hF, 1'b1);
        chk("len_rst with write", len, 32'd0);
        do_write(1'b1, 10'd100, 32'hDEADBEEF, 4'h0, 1'b0);
        chk("len zero strobe", len, 32'd0);
        do_write(1'b1, 10'd4, 32'h000000AA, 4'b0001, 1'b0);
        chk("len low strobe", len, 32'd20);
        do_load("after len_rst word", 12'd12, 2'b10, 32'h01020304, 1'b0);
        do_load("len boundary byte", 12'd19, 2'b00, 32'h000000AA, 1'b0);

        // Reset one cycle after rd_en flushes the in-flight load.
        rd_en   = 1'b1;
        rd_addr = 12'd0;
        rd_size = 2'b10;
        @(posedge clk); #1;
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("flush during reset valid", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("flush len", len, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("flush post%0d valid", i), 32'(rd_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/packet_ram_unaligned.md
Name: packet_ram_unaligned

Overview:
Next-generation packet buffer for the BPF VM packet memory. It is a parametrised-width word RAM with a byte-strobed write port and an independent byte-addressed read port. The read port performs unaligned 1/2/4-byte loads in hardware: it fetches two adjacent words, then extracts and zero-extends the addressed bytes in network (big-endian) order. It tracks packet length in bytes and flags out-of-bounds loads so the CPU can reject the packet.

Parameters:
- ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, RAM word width. Legal values are 32 and 64 only; any other value is an elaboration error.
- BYTES (localparam), DATA_WIDTH/8, bytes per word.
- BA_WIDTH (localparam), ADDR_WIDTH+$clog2(BYTES), byte-address width.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  word address.
- wr_data  in  DATA_WIDTH  write data. Bits [DATA_WIDTH-1:DATA_WIDTH-8] hold the lowest-address byte.
- wr_strb  in  BYTES  byte enables. wr_strb[i] covers wr_data[8i+7:8i]; the MSB strobe maps to the lowest byte offset.
- rd_en  in  1  load request, accepted every cycle (no backpressure).
- rd_addr  in  BA_WIDTH  byte address.
- rd_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- rd_data  out  32  zero-extended result, right-justified.
- rd_valid  out  1  result strobe.
- rd_oob  out  1  out-of-bounds flag, qualified by rd_valid.
- len_rst  in  1  synchronous clear of len.
- len  out  32  packet length in bytes.

Behaviour:
- Reset (asynchronous, rst_n=0): rd_valid=0, rd_oob=0, rd_data=0, len=0, pipeline valid bits cleared. RAM contents are not reset.
- Write: when wr_en=1, each byte with its strobe set is written at the clock edge. Bytes with a cleared strobe keep their old value. wr_strb=0 performs no write and leaves len unchanged.
- Read pipeline, fixed latency 2:
  - Cycle 0 (rd_en sampled): word index w = rd_addr>>log2(BYTES). Words w and (w+1) mod depth are fetched; byte offset, size and the out-of-bounds decision are registered.
  - Cycle 1: RAM outputs valid. The two words are concatenated, shifted left by offset*8, the top size bytes are taken and zero-extended into the stage-2 registers.
  - Cycle 2: rd_valid=1 with rd_data and rd_oob.
- Throughput is one load per cycle. Back-to-back rd_en produces back-to-back rd_valid in the same order.
- rd_data holds its last value when rd_valid=0.
- Read-during-write to the same word returns the old data (read-first).
- Top-of-RAM wrap: word w+1 wraps to 0. The wrapped data is returned as fetched; the OOB logic is what catches it.
- len update:
  - On a write with wr_strb≠0: len <= max(len, wr_addr*BYTES + hi + 1), where hi is the largest byte offset whose strobe is set. Computed in 32-bit arithmetic with no saturation.
  - len_rst has priority over this update: on simultaneous len_rst and wr_en, len becomes 0 but the RAM write still occurs.
- Reset asserted mid-read flushes all in-flight loads; no rd_valid is produced for them.

Optional Feature:
- Macro: PACKET_RAM_OOB_CHECK_EN.
- Defined:
  - At cycle 0, rd_addr + nbytes(rd_size) > len sets the registered oob bit. The comparison uses the len value on that cycle, i.e. before any same-cycle update.
  - On the matching result, rd_oob=1 and rd_data is forced to 0.
- Not defined: rd_oob is tied to 0, rd_data is never masked, and no comparator is built.

Decomposition:
- Package packet_ram_pkg holds:
  - rd_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - function nbytes(size), returning 1, 2 or 4;
  - function strb_hi(strb), returning the highest offset with a set strobe.
- Sub-module packet_ram_2r1w: one write port with byte enables plus two synchronous read ports. It is built as two identical simple-dual-port BRAM copies sharing the write port. The top level owns address generation, the alignment shifter, len tracking and OOB logic.

Test Plan (DATA_WIDTH=32, macro defined unless noted):
- Write word0=0x11223344 and word1=0x55667788, both with strb=1111 → len=8. Word load at rd_addr=3 → rd_data=0x44556677 two cycles later, rd_oob=0.
- Byte load at rd_addr=5 → 0x00000066. Then half load at rd_addr=7 (7+2>8) → rd_oob=1, rd_data=0. Rerun with the macro undefined → rd_oob=0 and rd_data=0x88xx, where xx is the word2 byte0 content.
- Write word2 data=0xAABBCCDD with strb=0100 → len=10. Byte load at rd_addr=9 → 0xBB; byte load at rd_addr=8 → prior contents unchanged.
- len_rst and wr_en in the same cycle → len=0 afterwards, and the written data is still readable.
- Four consecutive rd_en cycles at addresses 0, 1, 2, 3 (word size) → four consecutive rd_valid with 0x11223344, 0x22334455, 0x33445566, 0x44556677.
- rst_n pulsed low one cycle after rd_en → rd_valid stays 0, len=0, and no stale result appears after reset release.
